prim_packer_arb: RTL
====================

PRIM_PACKER_ARB -- requirements
Module: prim_packer_arb

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter InW, default 32, requester data/mask width, equal to the downstream packer input width.
REQ-003 SHALL have parameter WdogCycles, default 256, idle-while-granted limit (used only when the watchdog macro is defined).
REQ-004 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset. One clock; reset is synchronous and active-low.
REQ-005 SHALL have ports: req_valid_i  in  NumReq  per-requester beat valid; req_data_i  in  NumReq*InW  data; req_mask_i  in  NumReq*InW  mask; req_last_i  in  NumReq  final beat of a transfer; req_ready_o  out  NumReq  per-requester accept.
REQ-006 SHALL have ports: valid_o  out  1; data_o  out  InW; mask_o  out  InW; ready_i  in  1 (packer input side).
REQ-007 SHALL have ports: flush_o  out  1  packer flush request; flush_done_i  in  1  packer flush complete.
REQ-008 SHALL have ports: gnt_idx_o  out  $clog2(NumReq)  current owner; busy_o  out  1  not Idle; err_o  out  1  watchdog pulse.

Function
REQ-009 SHALL implement FSM states Idle, Grant, Flush, FlushWait.
REQ-010 In Idle, when any req_valid_i is 1, SHALL latch the winner into gnt_idx and enter Grant on the next edge; no beat is accepted in Idle.
REQ-011 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod NumReq; last_owner resets to NumReq-1, so requester 0 wins first.
REQ-012 In Grant: valid_o = req_valid_i[gnt]; data_o/mask_o = slice gnt; req_ready_o[gnt] = ready_i; all other req_ready_o = 0.
REQ-013 A beat is accepted when valid_o && ready_i; accepted beat with req_last_i[gnt]=1 SHALL move to Flush on the next edge.
REQ-014 In Flush: flush_o=1 for exactly one cycle, valid_o=0, all req_ready_o=0; then FlushWait.
REQ-015 In FlushWait: flush_o=0, valid_o=0; on flush_done_i=1 SHALL set last_owner=gnt and return to Idle on the next edge.
REQ-016 flush_done_i outside FlushWait SHALL be ignored.
REQ-017 Owner SHALL be held across beats with req_valid_i[gnt] low; no preemption by other requesters.
REQ-018 valid_o, data_o, mask_o SHALL be 0 outside Grant; no combinational path from ready_i to valid_o.
REQ-019 gnt_idx_o reflects latched owner; busy_o = (state != Idle).
REQ-020 Minimum per-transfer overhead SHALL be 3 cycles (Idle arbitration, Flush, >=1 FlushWait).

Reset
REQ-021 On rst_ni=0 at a clock edge: state=Idle, last_owner=NumReq-1, gnt_idx=0, watchdog counter=0.
REQ-022 Outputs after reset: valid_o=0, data_o=0, mask_o=0, req_ready_o=0, flush_o=0, busy_o=0, err_o=0.
REQ-023 Reset mid-Grant or mid-FlushWait SHALL abandon the transfer with no flush issued; the packer is reset on the same reset.

Configuration
REQ-024 Macro PRIM_PACKER_ARB_WDOG_EN defined: a counter counts Grant cycles with req_valid_i[gnt]=0, clearing on any accepted beat; at WdogCycles it SHALL pulse err_o for 1 cycle and force Flush.
REQ-025 Macro undefined: no counter, err_o tied 0, Grant exits only via req_last_i.

Structure
REQ-026 Package prim_packer_arb_pkg SHALL hold the FSM state enum (arb_st_e) and the default-parameter constants.
REQ-027 Round-robin selection SHALL be sub-module prim_packer_arb_rr (inputs: req vector, last_owner; outputs: winner index, any).

Verification
REQ-028 Req 0 alone sends 3 beats, last on the 3rd, ready_i=1 -> 3 accepts, one flush_o pulse, busy_o=0 one cycle after flush_done_i.
REQ-029 Req 0 and req 2 both pending from reset -> req 0 served first, then req 2, then req 0 again if still pending.
REQ-030 ready_i=0 for 5 cycles while granted -> valid_o stays 1, data_o stable, req_ready_o[gnt]=0.
REQ-031 flush_done_i held 1 during Grant -> no state change; FlushWait exits only on later flush_done_i.
REQ-032 WDOG_EN, WdogCycles=8, owner silent 8 cycles -> err_o pulse, flush_o pulse, next requester granted.
REQ-033 rst_ni=0 in FlushWait -> next cycle Idle, all outputs 0, req 0 wins next arbitration.

Source files
------------

// File: rtl/prim_packer_arb_pkg.sv
// prim_packer_arb_pkg
// Shared types and default parameters for the packer-input arbiter:
//   - arb_st_e       : arbiter FSM state encoding
//   - Def*           : default values for the top-level parameters
//   - idx_width()    : index width helper with a one-bit floor
package prim_packer_arb_pkg;

  // Default number of requesters sharing the packer.
  localparam int DefNumReq     = 4;
  // Default beat width (data and mask), equal to the packer input width.
  localparam int DefInW        = 32;
  // Default idle-while-granted limit for the optional watchdog.
  localparam int DefWdogCycles = 256;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StGrant     = 2'd1,
    StFlush     = 2'd2,
    StFlushWait = 2'd3
  } arb_st_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prim_packer_arb_rr.sv
// prim_packer_arb_rr
// Combinational round-robin picker. The search begins at the requester
// just after last_owner and wraps, so the most recent owner is the lowest
// priority. 'any' is high when at least one request is present; 'winner'
// is only meaningful while 'any' is high.
module prim_packer_arb_rr
  import prim_packer_arb_pkg::*;
#(
  parameter int NumReq = DefNumReq,
  parameter int IdxW   = idx_width(DefNumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last_owner,
  output logic [IdxW-1:0]   winner,
  output logic              any
);

  logic [IdxW-1:0] cand_idx;

  // Walk the requesters in rotated order and keep the first one found.
  always_comb begin
    winner   = '0;
    any      = 1'b0;
    cand_idx = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand_idx = IdxW'((int'(last_owner) + k) % NumReq);
      if (!any && req[cand_idx]) begin
        any    = 1'b1;
        winner = cand_idx;
      end
    end
  end

endmodule

// File: rtl/prim_packer_arb.sv
// prim_packer_arb
// Shares one packer input among NumReq requesters. A requester owns the
// packer for a whole transfer (until its last beat is accepted); each
// transfer is closed by a one-cycle flush request and a wait for the
// packer's flush completion before the next arbitration.
//
// Optional feature macro: PRIM_PACKER_ARB_WDOG_EN
//   defined   - a watchdog counts granted cycles in which the owner has no
//               beat; after WdogCycles such cycles it pulses err_o and
//               forces the flush so a stalled owner cannot hold the packer.
//   undefined - no watchdog, err_o is held low, Grant ends only on a last beat.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// StIdle      | no owner; arbitrate among valid requesters, accept nothing
// StGrant     | owner gnt_q streams beats straight through to the packer
// StFlush     | one-cycle flush request to the packer, no traffic
// StFlushWait | wait for flush_done_i, then record owner for round-robin
module prim_packer_arb
  import prim_packer_arb_pkg::*;
#(
  parameter int NumReq     = DefNumReq,
  parameter int InW        = DefInW,
  parameter int WdogCycles = DefWdogCycles
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,

  input  logic [NumReq-1:0]          req_valid_i,
  input  logic [NumReq*InW-1:0]      req_data_i,
  input  logic [NumReq*InW-1:0]      req_mask_i,
  input  logic [NumReq-1:0]          req_last_i,
  output logic [NumReq-1:0]          req_ready_o,

  output logic                       valid_o,
  output logic [InW-1:0]             data_o,
  output logic [InW-1:0]             mask_o,
  input  logic                       ready_i,

  output logic                       flush_o,
  input  logic                       flush_done_i,

  output logic [$clog2(NumReq)-1:0]  gnt_idx_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int IdxW = $clog2(NumReq);
  // After reset the "previous owner" is the highest index so that the
  // rotated search starts at requester 0.
  localparam logic [IdxW-1:0] LastRst = IdxW'(NumReq - 1);

  arb_st_e         state_q;
  logic [IdxW-1:0] gnt_q;
  logic [IdxW-1:0] last_q;

  logic [IdxW-1:0] rr_winner;
  logic            rr_any;

  logic [InW-1:0]  data_arr [NumReq];
  logic [InW-1:0]  mask_arr [NumReq];

  logic            granted;
  logic            owner_valid;
  logic            accept;
  logic            wdog_fire;

  // Unpack the flat requester buses so the owner can be selected by index.
  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign data_arr[g] = req_data_i[g*InW +: InW];
    assign mask_arr[g] = req_mask_i[g*InW +: InW];
  end

  prim_packer_arb_rr #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr (
    .req        (req_valid_i),
    .last_owner (last_q),
    .winner     (rr_winner),
    .any        (rr_any)
  );

  assign granted     = (state_q == StGrant);
  assign owner_valid = req_valid_i[gnt_q];
  assign accept      = granted && owner_valid && ready_i;

  // Owner-to-packer steering; everything is quiet outside Grant. valid_o
  // depends only on the owner's valid, never on ready_i.
  always_comb begin
    valid_o     = 1'b0;
    data_o      = '0;
    mask_o      = '0;
    req_ready_o = '0;
    if (granted) begin
      valid_o            = owner_valid;
      data_o             = data_arr[gnt_q];
      mask_o             = mask_arr[gnt_q];
      req_ready_o[gnt_q] = ready_i;
    end
  end

  assign flush_o   = (state_q == StFlush);
  assign busy_o    = (state_q != StIdle);
  assign gnt_idx_o = gnt_q;

  // Arbiter FSM: ownership, transfer close-out and round-robin history.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= LastRst;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rr_any) begin
            gnt_q   <= rr_winner;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (accept && req_last_i[gnt_q]) begin
            state_q <= StFlush;
          end else if (wdog_fire) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          state_q <= StFlushWait;
        end
        StFlushWait: begin
          if (flush_done_i) begin
            last_q  <= gnt_q;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef PRIM_PACKER_ARB_WDOG_EN
  localparam int WdW = (WdogCycles > 1) ? $clog2(WdogCycles) : 1;
  // Down-counter holds the number of silent granted cycles still allowed
  // before the one that trips the watchdog.
  localparam logic [WdW-1:0] WdogLoad = WdW'(WdogCycles - 1);

  logic [WdW-1:0] wdog_q;
  logic           err_q;

  assign wdog_fire = granted && !owner_valid && (wdog_q == '0);

  // Silent-cycle budget: reloaded outside Grant and on every accepted beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wdog_fire;
      if (!granted || accept) begin
        wdog_q <= WdogLoad;
      end else if (!owner_valid && (wdog_q != '0)) begin
        wdog_q <= wdog_q - WdW'(1);
      end
    end
  end

  assign err_o = err_q;
`else
  assign wdog_fire = 1'b0;
  // Without the watchdog the limit has no effect and err_o stays low.
  assign err_o     = (WdogCycles > 0) ? 1'b0 : 1'b0;
`endif

endmodule
